truth_table_sweeper: RTL and testbench

- Synthesisable, parametrised exhaustive truth-table tester for combinational logic blocks of N_IN inputs and one output.
- On start, drives every input combination 0 .. 2^N_IN-1 in ascending order, holding each for DWELL cycles.
- Samples the DUT output once per vector, compares it against the expected table, and records the captured table, mismatch count and first failing index.
- Sits beside a combinational DUT in self-checking benches and on-board built-in self-test.

---
 rtl/tt_pkg.sv | 25 ++
 rtl/tt_dwell_counter.sv | 39 +++
 rtl/truth_table_sweeper.sv | 146 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_pkg
// Brief    : Shared types and helpers for the truth-table sweeper.
// Revision : 1.0 - initial release
// ============================================================================
package tt_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Largest supported input count
    localparam int unsigned TT_MAX_N_IN = 8;

    // Number of input vectors for an n-input block
    function automatic int unsigned tt_vcount(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage : tt_pkg
`default_nettype wire

// File: rtl/tt_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : tt_dwell_counter
// Brief    : Counts the cycles a vector is held; flags the final dwell cycle
//            and wraps to zero on its own.
// Revision : 1.0 - initial release
// ============================================================================
module tt_dwell_counter
    import tt_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    // A one-bit counter still works for DWELL == 1: it simply sits at zero
    localparam int unsigned     c_CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DWELL - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_count;

    // Advance while enabled, wrap after the final dwell cycle
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_LAST) ? '0 : (r_count + c_ONE);
        end
    end

    assign o_last = (r_count == c_LAST);

endmodule : tt_dwell_counter
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Exhaustive truth-table tester. Walks every input vector of an
//            N_IN-input combinational block, samples its output once per
//            vector and scores it against EXP_TABLE.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned                  N_IN      = 4,
    parameter int unsigned                  DWELL     = 4,
    parameter logic [tt_vcount(N_IN)-1:0]   EXP_TABLE = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         loop,
    output logic [N_IN-1:0]              stim,
    input  logic                         dut_z,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                err_count,
    output logic                         fail_valid,
    output logic [N_IN-1:0]              first_fail_idx,
    output logic [tt_vcount(N_IN)-1:0]   captured
);

    localparam int unsigned     c_V        = tt_vcount(N_IN);
    localparam logic [N_IN-1:0] c_LAST_IDX = '1;
    localparam logic [N_IN-1:0] c_ONE_IDX  = N_IN'(1);
    localparam logic [N_IN:0]   c_ERR_MAX  = (N_IN + 1)'(c_V);
    localparam logic [N_IN:0]   c_ONE_ERR  = (N_IN + 1)'(1);

    tt_state_e         r_state;
    logic [N_IN-1:0]   r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_IN:0]     r_err_count;
    logic              r_fail_valid;
    logic [N_IN-1:0]   r_first_fail_idx;
    logic [c_V-1:0]    r_captured;

    logic              w_sweep_begin;
    logic              w_dwell_last;
    logic              w_sample;
    logic              w_mismatch;

    // A fresh sweep starts either from IDLE on start or from DONE on loop
    assign w_sweep_begin = ((r_state == IDLE) && start) || ((r_state == DONE) && loop);
    assign w_sample      = (r_state == RUN) && w_dwell_last;
    // Case inequality so an unknown DUT output scores as a mismatch
    assign w_mismatch    = (dut_z !== EXP_TABLE[r_idx]);

    tt_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_sweep_begin),
        .i_en   (r_state == RUN),
        .o_last (w_dwell_last)
    );

    // Sweep controller: vector stepping, scoring and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_idx            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_fail_valid     <= 1'b0;
            r_first_fail_idx <= '0;
            r_captured       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // results hold until the next accepted start
                end
                RUN: begin
                    if (w_sample) begin
                        r_captured[r_idx] <= dut_z;
                        if (w_mismatch) begin
                            if (r_err_count != c_ERR_MAX) begin
                                r_err_count <= r_err_count + c_ONE_ERR;
                            end
                            if (!r_fail_valid) begin
                                r_fail_valid     <= 1'b1;
                                r_first_fail_idx <= r_idx;
                            end
                        end
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + c_ONE_IDX;
                        end
                    end
                end
                DONE: begin
                    // err_count already includes the last vector here
                    r_done <= 1'b1;
                    r_pass <= (r_err_count == '0);
                    if (!loop) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Later assignments take priority over the state-specific ones
            if (w_sweep_begin) begin
                r_state          <= RUN;
                r_busy           <= 1'b1;
                r_idx            <= '0;
                r_err_count      <= '0;
                r_fail_valid     <= 1'b0;
                r_first_fail_idx <= '0;
                r_captured       <= '0;
                // On a loop restart pass keeps the verdict being pulsed out
                if (r_state == IDLE) begin
                    r_pass <= 1'b0;
                end
            end
        end
    end

    assign stim           = r_idx;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign fail_valid     = r_fail_valid;
    assign first_fail_idx = r_first_fail_idx;
    assign captured       = r_captured;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sweeper
// Brief    : Self-checking bench for truth_table_sweeper. Three instances:
//            A (4 inputs, dwell 4, table A5C3) with a fault-injected DUT,
//            B (4 inputs, dwell 4, table 0000) with a stuck-at-1 DUT,
//            C (2 inputs, dwell 1) used for looping sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    localparam int unsigned A_D   = 4;
    localparam int unsigned A_V   = 16;
    localparam int unsigned A_LAT = A_V * A_D + 1;
    localparam int unsigned C_D   = 1;
    localparam int unsigned C_V   = 4;
    localparam int unsigned C_LAT = C_V * C_D + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    // Reference tables and fault masks applied to the modelled DUTs
    logic [15:0] tbl_a   = 16'hA5C3;
    logic [15:0] fault_a = '0;
    logic [3:0]  tbl_c   = 4'b0110;
    logic [3:0]  fault_c = '0;

    logic        start_a = 1'b0, loop_a = 1'b0, z_a;
    logic [3:0]  stim_a, ffi_a;
    logic        busy_a, done_a, pass_a, fv_a;
    logic [4:0]  err_a;
    logic [15:0] cap_a;

    logic        start_b = 1'b0, loop_b = 1'b0, z_b;
    logic [3:0]  stim_b, ffi_b;
    logic        busy_b, done_b, pass_b, fv_b;
    logic [4:0]  err_b;
    logic [15:0] cap_b;

    logic        start_c = 1'b0, loop_c = 1'b0, z_c;
    logic [1:0]  stim_c, ffi_c;
    logic        busy_c, done_c, pass_c, fv_c;
    logic [2:0]  err_c;
    logic [3:0]  cap_c;

    assign z_a = tbl_a[stim_a] ^ fault_a[stim_a];
    assign z_b = 1'b1;
    assign z_c = tbl_c[stim_c] ^ fault_c[stim_c];

    truth_table_sweeper #(.N_IN(4), .DWELL(A_D), .EXP_TABLE(16'hA5C3)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .loop(loop_a), .stim(stim_a),
        .dut_z(z_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_valid(fv_a), .first_fail_idx(ffi_a), .captured(cap_a)
    );

    truth_table_sweeper #(.N_IN(4), .DWELL(A_D), .EXP_TABLE(16'h0000)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .loop(loop_b), .stim(stim_b),
        .dut_z(z_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_valid(fv_b), .first_fail_idx(ffi_b), .captured(cap_b)
    );

    truth_table_sweeper #(.N_IN(2), .DWELL(C_D), .EXP_TABLE(4'b0110)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .loop(loop_c), .stim(stim_c),
        .dut_z(z_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .fail_valid(fv_c), .first_fail_idx(ffi_c), .captured(cap_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Index of the lowest set bit (0 when none)
    function automatic int first_set(input logic [15:0] m);
        int r = -1;
        for (int i = 0; i < 16; i++) begin
            if (m[i] && r < 0) r = i;
        end
        return (r < 0) ? 0 : r;
    endfunction

    // Vector expected on stim t cycles after start acceptance
    function automatic int exp_stim(input int t, input int d, input int v);
        return ((t / d) < v) ? (t / d) : (v - 1);
    endfunction

    task automatic check_reset_a(input string tag);
        check_eq({tag, "_stim"}, stim_a, 0);
        check_eq({tag, "_busy"}, busy_a, 0);
        check_eq({tag, "_done"}, done_a, 0);
        check_eq({tag, "_pass"}, pass_a, 0);
        check_eq({tag, "_err"},  err_a,  0);
        check_eq({tag, "_fv"},   fv_a,   0);
        check_eq({tag, "_ffi"},  ffi_a,  0);
        check_eq({tag, "_cap"},  cap_a,  0);
    endtask

    // One sweep on instance A; optional mid-sweep reset or stray starts
    task automatic sweep_a(input logic [15:0] mask, input int rst_at_vec, input bit stray_start);
        int  t;
        bit  stim_ok;
        bit  quiet;
        fault_a = mask;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("a_busy_on_start", busy_a, 1);
        t       = 0;
        stim_ok = 1'b1;
        while (!done_a && t <= int'(A_LAT) + 10) begin
            if (int'(stim_a) != exp_stim(t, A_D, A_V)) stim_ok = 1'b0;
            if (rst_at_vec >= 0 && int'(stim_a) == rst_at_vec) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_reset_a("a_midrst");
                quiet = 1'b1;
                repeat (A_LAT) begin
                    tick();
                    if (done_a || busy_a) quiet = 1'b0;
                end
                check_eq("a_midrst_quiet", quiet, 1);
                return;
            end
            start_a = (stray_start && (t == 10 || t == 41)) ? 1'b1 : 1'b0;
            tick();
            t++;
        end
        start_a = 1'b0;
        check_eq("a_done_latency", t, A_LAT);
        check_eq("a_stim_seq", stim_ok, 1);
        check_eq("a_err", err_a, $countones(mask));
        check_eq("a_pass", pass_a, (mask == 16'h0) ? 1 : 0);
        check_eq("a_fail_valid", fv_a, (mask != 16'h0) ? 1 : 0);
        check_eq("a_first_fail", ffi_a, first_set(mask));
        check_eq("a_captured", cap_a, tbl_a ^ mask);
        tick();
        check_eq("a_busy_after", busy_a, 0);
        check_eq("a_done_pulse", done_a, 0);
        repeat (3) tick();
        check_eq("a_hold_err", err_a, $countones(mask));
        check_eq("a_hold_cap", cap_a, tbl_a ^ mask);
        check_eq("a_hold_pass", pass_a, (mask == 16'h0) ? 1 : 0);
    endtask

    // Looping sweeps on instance C, then leave the loop
    task automatic loop_c_run(input logic [3:0] mask, input int sweeps);
        int t;
        int p;
        int ndone;
        bit stim_ok, done_ok, pass_ok, clr_ok, busy_ok;
        fault_c = mask;
        loop_c  = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        stim_ok = 1'b1; done_ok = 1'b1; pass_ok = 1'b1; clr_ok = 1'b1; busy_ok = 1'b1;
        ndone   = 0;
        for (t = 0; t < sweeps * int'(C_LAT); t++) begin
            p = t % int'(C_LAT);
            if (int'(stim_c) != exp_stim(p, C_D, C_V)) stim_ok = 1'b0;
            if (done_c != (t > 0 && p == 0)) done_ok = 1'b0;
            if (!busy_c) busy_ok = 1'b0;
            if (done_c) begin
                ndone++;
                if (pass_c != (mask == 4'h0)) pass_ok = 1'b0;
                if (err_c != 0 || cap_c != 0 || fv_c) clr_ok = 1'b0;
            end
            tick();
        end
        loop_c = 1'b0;
        check_eq("c_stim_seq", stim_ok, 1);
        check_eq("c_done_period", done_ok, 1);
        check_eq("c_done_count", ndone, sweeps - 1);
        check_eq("c_busy_held", busy_ok, 1);
        check_eq("c_pass_each", pass_ok, 1);
        check_eq("c_cleared", clr_ok, 1);
        t = 0;
        while (busy_c && t < 20) begin
            tick();
            t++;
        end
        check_eq("c_exit_busy", busy_c, 0);
        check_eq("c_exit_done", done_c, 1);
        check_eq("c_exit_pass", pass_c, (mask == 4'h0) ? 1 : 0);
        check_eq("c_exit_err", err_c, $countones(mask));
        check_eq("c_exit_cap", cap_c, tbl_c ^ mask);
        tick();
    endtask

    initial begin
        int t;
        logic [15:0] m;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_a("a_reset");
        check_eq("b_reset_busy", busy_b, 0);
        check_eq("c_reset_stim", stim_c, 0);

        // Matching DUT, then the two-fault case
        sweep_a(16'h0000, -1, 1'b0);
        sweep_a(16'h0208, -1, 1'b0);

        // Random fault patterns
        repeat (3) begin
            m = 16'($urandom) & 16'($urandom);
            sweep_a(m, -1, 1'b0);
        end

        // Stray start pulses while busy
        sweep_a(16'($urandom), -1, 1'b1);

        // Reset at vector 7, then a full normal sweep
        sweep_a(16'h0004, 7, 1'b0);
        sweep_a(16'h8000, -1, 1'b0);
        sweep_a(16'hFFFF, -1, 1'b0);

        // Stuck-at-1 against an all-zero table, start held high throughout
        start_b = 1'b1;
        tick();
        t = 0;
        while (!done_b && t <= int'(A_LAT) + 10) begin
            tick();
            t++;
        end
        check_eq("b_done_latency", t, A_LAT);
        check_eq("b_err", err_b, 16);
        check_eq("b_pass", pass_b, 0);
        check_eq("b_first_fail", ffi_b, 0);
        check_eq("b_fail_valid", fv_b, 1);
        check_eq("b_captured", cap_b, 16'hFFFF);
        check_eq("b_idle_busy", busy_b, 0);
        tick();
        check_eq("b_restart_busy", busy_b, 1);
        check_eq("b_restart_err", err_b, 0);
        t = 0;
        while (!done_b && t <= int'(A_LAT) + 10) begin
            tick();
            t++;
        end
        check_eq("b_done_latency2", t, A_LAT);
        start_b = 1'b0;
        tick();
        check_eq("b_stop_busy", busy_b, 0);

        // Looping short sweeps
        loop_c_run(4'h0, 4);
        loop_c_run(4'($urandom_range(1, 15)), 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_truth_table_sweeper
`default_nettype wire
